// File: rtl/dcache_refill_controller_pkg.sv
// dcache_pkg: shared constants, FSM state type and address slicing helpers for
// the direct-mapped read-only data cache controller.
//   Word address layout: {tag[14:10], index[9:2], offset[1:0]}.
package dcache_pkg;

  localparam int ADDR_W    = 15;                          // word address width
  localparam int OFFSET_W  = 2;                           // word-in-block bits
  localparam int INDEX_W   = 8;                           // line index bits
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W; // derived tag width
  localparam int CNT_W     = 16;                          // perf counter width
  localparam int DATA_W    = 32;                          // word width
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int WORDS     = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  // Block base: memory adds the beat offset itself, so low bits are zero.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_refill_controller_if.sv
// dcache_mem_if: block-refill bus between the cache controller (master) and
// main memory (slave).
//   main_mem_miss    master->slave  block request, held high for the whole refill
//   main_mem_offset  master->slave  beat number 0..3
//   main_mem_address master->slave  block base address (low bits zero)
//   main_mem_ready   slave->master  beat data valid this cycle (may be comb from miss)
//   main_mem_data    slave->master  beat data
// Handshake: a beat transfers at every rising edge where main_mem_miss and
// main_mem_ready are both high; the master then advances main_mem_offset. With
// ready low, offset, address and miss hold unchanged.
interface dcache_mem_if;
  import dcache_pkg::*;

  logic                main_mem_miss;
  logic [OFFSET_W-1:0] main_mem_offset;
  logic [ADDR_W-1:0]   main_mem_address;
  logic                main_mem_ready;
  logic [DATA_W-1:0]   main_mem_data;

  modport master (
    output main_mem_miss, main_mem_offset, main_mem_address,
    input  main_mem_ready, main_mem_data
  );

  modport slave (
    input  main_mem_miss, main_mem_offset, main_mem_address,
    output main_mem_ready, main_mem_data
  );
endinterface

// File: rtl/dcache_refill_controller_store.sv
// dcache_store: valid vector, tag array and data array of the cache.
//   clk, rst            clock, sync active-high reset (clears valid bits only)
//   rd_index_i/offset_i combinational read address
//   rd_valid_o/tag_o/word_o  read results
//   word_we_i + wr_*    synchronous single-word write
//   line_we_i + wr_tag_i     synchronous tag write and valid set
module dcache_store
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [DATA_W-1:0]   rd_word_o,
  input  logic                word_we_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                line_we_i,
  input  logic [TAG_W-1:0]    wr_tag_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]    data_mem [NUM_LINES][WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only valid bits gate their use.
  always_ff @(posedge clk) begin
    if (word_we_i) begin
      data_mem[wr_index_i][wr_offset_i] <= wr_data_i;
    end
    if (line_we_i) begin
      tag_mem[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_mem[rd_index_i];
  assign rd_word_o  = data_mem[rd_index_i][rd_offset_i];

endmodule

// File: rtl/dcache_refill_controller.sv
// dcache_refill_controller: direct-mapped read-only data cache, 256 lines of
// 4 x 32-bit words, refilled one word per beat from main memory.
//   clk, rst              clock, sync active-high reset
//   cpu_req, cpu_addr     load request (sampled in IDLE only)
//   cpu_ready, cpu_data   one-cycle response pulse, data held until next pulse
//   mem                   main memory refill bus (master side)
//   hit_count, miss_count wrapping performance counters
//   state_o               current FSM state for observation
module dcache_refill_controller
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_data,
  dcache_mem_if.master        mem,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output state_t              state_o
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                first_q, first_d;   // current lookup is the request's first
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                miss_q, miss_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_word;
  logic                hit;
  logic                beat_fire;
  logic                last_beat;

  assign hit       = rd_valid && (rd_tag == addr_tag(addr_q));
  // Writes are gated by rst so a reset edge never completes a partial line.
  assign beat_fire = (state_q == REFILL) && mem.main_mem_ready && !rst;
  assign last_beat = beat_fire && (beat_q == OFFSET_W'(WORDS - 1));

  dcache_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (addr_index(addr_q)),
    .rd_offset_i(addr_offset(addr_q)),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_word_o  (rd_word),
    .word_we_i  (beat_fire),
    .wr_index_i (addr_index(addr_q)),
    .wr_offset_i(beat_q),
    .wr_data_i  (mem.main_mem_data),
    .line_we_i  (last_beat),
    .wr_tag_i   (addr_tag(addr_q))
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      first_q    <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      miss_q     <= 1'b0;
      beat_q     <= '0;
      base_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      first_q    <= first_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
      miss_q     <= miss_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : REFILL;
      REFILL:  if (last_beat) state_d = LOOKUP;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values.
  always_comb begin
    addr_d     = addr_q;
    first_d    = first_q;
    ready_d    = 1'b0;
    data_d     = data_q;
    miss_d     = miss_q;
    beat_d     = beat_q;
    base_d     = base_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          first_d = 1'b1;
        end
      end
      LOOKUP: begin
        if (hit) begin
          ready_d = 1'b1;
          data_d  = rd_word;
          // The re-lookup after a refill is not a genuine hit.
          if (first_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          first_d    = 1'b0;
          miss_d     = 1'b1;
          beat_d     = '0;
          base_d     = block_base(addr_q);
        end
      end
      REFILL: begin
        if (beat_fire) begin
          beat_d = beat_q + OFFSET_W'(1);
          if (last_beat) miss_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cpu_ready            = ready_q;
  assign cpu_data             = data_q;
  assign mem.main_mem_miss    = miss_q;
  assign mem.main_mem_offset  = beat_q;
  assign mem.main_mem_address = base_q;
  assign hit_count            = hit_cnt_q;
  assign miss_count           = miss_cnt_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_dcache_refill_controller.sv
// Directed bench for dcache_refill_controller with a behavioural main memory
// (mem[1024+k] = k+1, ready follows miss unless stalled) and expected queues
// for load data and refill beats.
module tb_dcache_refill_controller;
  import dcache_pkg::*;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_data;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  state_t            state_o;
  logic              stall;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0]          exp_q[$];   // expected load data
  logic [ADDR_W+OFFSET_W-1:0] beat_q[$];  // expected {address, offset} per beat
  logic [DATA_W-1:0]          mem [0:(1<<ADDR_W)-1];

  dcache_mem_if mem_bus ();

  dcache_refill_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_data  (cpu_data),
    .mem       (mem_bus.master),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .state_o   (state_o)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_bus.main_mem_ready = mem_bus.main_mem_miss && !stall;
  assign mem_bus.main_mem_data  =
    mem[mem_bus.main_mem_address + ADDR_W'(mem_bus.main_mem_offset)];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] a);
    return 32'(a) - 32'd1023;
  endfunction

  // Every transferring beat must match the next expected {address, offset}.
  always @(negedge clk) begin
    logic [ADDR_W+OFFSET_W-1:0] e;
    if (!rst && mem_bus.main_mem_ready) begin
      e = (beat_q.size() != 0) ? beat_q.pop_front() : '1;
      check("beat_addr_off",
            32'({mem_bus.main_mem_address, mem_bus.main_mem_offset}), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic read_req(input logic [ADDR_W-1:0] a, input logic exp_miss,
                          input int exp_lat);
    int   n;
    logic got;
    logic saw_miss;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    check("idle_before_req", 32'(state_o), 32'(IDLE));
    exp_q.push_back(ref_word(a));
    if (exp_miss) begin
      for (int k = 0; k < WORDS; k++)
        beat_q.push_back({block_base(a), OFFSET_W'(k)});
    end
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    n = 0; got = 1'b0; saw_miss = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_bus.main_mem_miss) saw_miss = 1'b1;
      if (cpu_ready) got = 1'b1;
    end
    e = exp_q.pop_front();
    check("miss_seen", 32'(saw_miss), 32'(exp_miss));
    if (!got) begin
      check("ready_timeout", 32'(got), 32'd1);
    end else begin
      check("ready_latency", 32'(n), 32'(exp_lat));
      check("load_data", cpu_data, e);
      @(negedge clk);
      check("ready_one_cycle", 32'(cpu_ready), 32'd0);
      check("data_held", cpu_data, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++)
      mem[i] = (i >= 1024) ? 32'(i - 1023) : (32'hDEAD_0000 | 32'(i));
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_data", cpu_data, 32'd0);
    check("rst_miss", 32'(mem_bus.main_mem_miss), 32'd0);
    check("rst_addr_off", 32'({mem_bus.main_mem_address, mem_bus.main_mem_offset}), 32'd0);
    check("rst_counts", 32'({hit_count, miss_count}), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    read_req(15'd1024, 1'b1, 7);
    check("miss_cnt_1", 32'(miss_count), 32'd1);
    check("hit_cnt_0", 32'(hit_count), 32'd0);
    read_req(15'd1026, 1'b0, 2);
    check("hit_cnt_1", 32'(hit_count), 32'd1);
    read_req(15'd2048, 1'b1, 7);
    read_req(15'd1024, 1'b1, 7);
    check("miss_cnt_3", 32'(miss_count), 32'd3);
    read_req(15'd9215, 1'b1, 7);
    read_req(15'd9212, 1'b0, 2);
    check("hit_cnt_2", 32'(hit_count), 32'd2);

    // Memory stalls for 3 cycles while beat 1 is pending.
    fork
      read_req(15'd5001, 1'b1, 10);
      begin
        n = 0;
        do begin
          @(posedge clk); #1; n++;
        end while (!(mem_bus.main_mem_miss && mem_bus.main_mem_offset == 2'd1) && n < 20);
        check("stall_reached_off1", 32'(mem_bus.main_mem_offset), 32'd1);
        stall = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_offset_hold", 32'(mem_bus.main_mem_offset), 32'd1);
          check("stall_miss_hold", 32'(mem_bus.main_mem_miss), 32'd1);
        end
        stall = 1'b0;
      end
    join
    check("miss_cnt_5", 32'(miss_count), 32'd5);

    // Reset in the middle of a refill of 1024.
    do_reset();
    @(negedge clk);
    beat_q.push_back({15'd1024, 2'd0});
    beat_q.push_back({15'd1024, 2'd1});
    cpu_req = 1'b1; cpu_addr = 15'd1024;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    n = 0;
    while (mem_bus.main_mem_offset !== 2'd2 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reached_beat2", 32'(mem_bus.main_mem_offset), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_miss", 32'(mem_bus.main_mem_miss), 32'd0);
    check("midrst_counts", 32'({hit_count, miss_count}), 32'd0);
    check("midrst_state", 32'(state_o), 32'(IDLE));
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_ready", 32'(cpu_ready), 32'd0);
    end
    check("midrst_beats_consumed", 32'(beat_q.size()), 32'd0);
    read_req(15'd1024, 1'b1, 7);
    check("post_rst_miss_cnt", 32'(miss_count), 32'd1);

    repeat (3) @(negedge clk);
    check("beats_all_seen", 32'(beat_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_refill_controller.md
Name: dcache_refill_controller

Overview:
- Direct-mapped, read-only data cache controller that sits between the CPU load path and main memory.
- Acts as initiator on the main memory interface: on a miss it requests one 4-word block, one word per beat, using main_mem_miss, main_mem_offset and main_mem_address, and consumes main_mem_ready and main_mem_data.
- Holds 256 lines of 4 x 32-bit words.
- Returns load data to the CPU with a one-cycle ready pulse and keeps hit and miss counters.

Parameters:
- ADDR_W, 15, word address width (32K words).
- OFFSET_W, 2, word-in-block bits (4 words per block).
- INDEX_W, 8, line index bits (256 lines).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W = 5, tag bits. Derived; not overridden.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  load request; sampled only in IDLE.
- cpu_addr  in  15  word address {tag[14:10], index[9:2], offset[1:0]}.
- cpu_ready  out  1  one-cycle pulse; cpu_data is valid in that cycle.
- cpu_data  out  32  loaded word; holds its value until the next pulse.
- main_mem_miss  out  1  block-fetch request, held high for the whole refill.
- main_mem_offset  out  2  beat number 0..3.
- main_mem_address  out  15  block base {tag, index, 2'b00}. Low bits are always zero because memory adds the offset.
- main_mem_ready  in  1  current beat's data is valid; may be combinational from main_mem_miss.
- main_mem_data  in  32  beat data.
- hit_count  out  16  lookups that hit on the first lookup.
- miss_count  out  16  lookups that missed.

Behaviour:
- Reset (sync, when rst=1 at an edge):
  - state goes to IDLE.
  - All 256 valid bits are cleared in one cycle.
  - cpu_ready, cpu_data, main_mem_miss, main_mem_offset, main_mem_address, hit_count and miss_count all become 0.
  - Tag and data arrays are not cleared.
- State machine (all outputs registered):
  - IDLE: cpu_req=1 latches cpu_addr and moves to LOOKUP. cpu_req is ignored in every other state.
  - LOOKUP, hit (valid[index] and tag matches):
    - cpu_data <= data[index][offset], cpu_ready <= 1 for one cycle, state -> IDLE.
    - hit_count increments only when this is the first lookup of the request.
  - LOOKUP, miss:
    - miss_count++, beat <= 0.
    - main_mem_miss <= 1, main_mem_address <= {tag, index, 2'b00}, main_mem_offset <= 0, state -> REFILL.
  - REFILL:
    - At each edge with main_mem_ready=1, write data[index][beat] <= main_mem_data and increment beat and main_mem_offset.
    - main_mem_ready=0 holds beat, offset and main_mem_miss unchanged.
    - On the beat-3 write: tag[index] <= tag, valid[index] <= 1, main_mem_miss <= 0, state -> LOOKUP. The re-lookup then hits and does not count as a hit.
- Latency, with the accept edge as E0:
  - Hit: cpu_ready high during cycle E0+2 only.
  - Miss with ready always high: cpu_ready high at E0+7.
  - Each low cycle of main_mem_ready adds one cycle.
- A refill overwrites the line (eviction). There is no write path and no dirty state.
- Counters are CNT_W bits wide and wrap from 0xFFFF to 0x0000.
- Reset mid-refill: main_mem_miss is 0 from the next cycle. The partial line stays invalid and no cpu_ready is issued.
- cpu_req held high across a completed request starts a new request at the IDLE cycle after the pulse.

Decomposition:
- Package dcache_pkg holds:
  - the width constants (ADDR_W, OFFSET_W, INDEX_W, TAG_W, CNT_W);
  - the state enum {IDLE, LOOKUP, REFILL};
  - address field slice helpers.
- Sub-module dcache_store holds the valid vector, tag array and data array:
  - combinational read by index;
  - synchronous word write and tag/valid write;
  - synchronous valid clear on rst.
- FSM and counters live in the top module.

Test Plan:
Memory model preloaded with mem[1024+k] = k+1, ready = miss.
- Reset, then read 1024:
  - main_mem_miss high for 4 cycles at address 1024, offsets 0,1,2,3.
  - cpu_ready at E0+7, cpu_data=1.
  - miss_count=1, hit_count=0.
- Then read 1026: cpu_ready at E0+2, data=3, no main_mem_miss, hit_count=1.
- Read 2048 (same index 0, different tag): refill at address 2048, data=1025. A following read of 1024 misses again with data=1, miss_count=3.
- Read 9215: refill base 9212, offsets 0..3, data=8192.
- Hold main_mem_ready low for 3 cycles while offset=1:
  - offset stays 1 and main_mem_miss stays high;
  - cpu_ready arrives at E0+10 with correct data.
- Assert rst during beat 2 of the 1024 refill:
  - main_mem_miss=0, counters=0, no cpu_ready;
  - a re-read of 1024 performs a full refill.
